// File: rtl/cksum_pkg.sv
// Shared types and helpers for the ones'-complement checksum engine.
// Used by cksum_engine and cksum_word_sum.
package cksum_pkg;

    typedef enum logic [2:0] {
        FREE  = 3'd0,
        SUM   = 3'd1,
        FOLD1 = 3'd2,
        FOLD2 = 3'd3,
        DONE  = 3'd4
    } cksum_state_e;

    localparam logic        CKSUM_MODE_GEN = 1'b0;
    localparam logic        CKSUM_MODE_VER = 1'b1;
    localparam logic [15:0] CKSUM_ALL_ONES = 16'hFFFF;

    // One end-around-carry fold step: high half added into low half.
    function automatic logic [16:0] fold32to17(input logic [31:0] value);
        return {1'b0, value[31:16]} + {1'b0, value[15:0]};
    endfunction

endpackage

// File: rtl/cksum_word_sum.sv
// Combinational sum of NUM_WORDS big-endian 16-bit words into a 20-bit partial.
// Eight words of 16'hFFFF stay below 2^19, so 20 bits never overflow.
module cksum_word_sum
    import cksum_pkg::*;
#(
    parameter int NUM_WORDS = 2
) (
    input  logic [16*NUM_WORDS-1:0] words,
    output logic [19:0]             partial
);

    logic [19:0] partial_s;

    // Accumulate every masked word of this beat.
    always_comb begin
        partial_s = 20'd0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            partial_s = partial_s + {4'd0, words[16*w +: 16]};
        end
    end

    assign partial = partial_s;

endmodule

// File: rtl/cksum_engine.sv
// Internet checksum over a byte window of the parsed header, BYTES_PER_CYCLE bytes per clock.
// Optional macro CKSUM_SEED_EN adds seed_i as the initial accumulator (pseudo-header sum).
module cksum_engine
    import cksum_pkg::*;
#(
    parameter int HDR_MAX_LEN     = 64,
    parameter int BYTES_PER_CYCLE = 4,
    parameter int ADDR_W          = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [8*HDR_MAX_LEN-1:0] pkt_hdr_i,
    input  logic [ADDR_W-1:0]        field_start_i,
    input  logic [ADDR_W-1:0]        field_len_i,
    input  logic                     mode_i,
`ifdef CKSUM_SEED_EN
    input  logic [31:0]              seed_i,
`endif
    output logic [15:0]              cksum_val_o,
    output logic                     cksum_ok_o,
    output logic                     range_err_o,
    output logic                     busy_o,
    output logic                     cksum_ready_o
);

    localparam int NUM_WORDS = BYTES_PER_CYCLE / 2;
    // Two extra bits cover start + len plus one beat of overshoot.
    localparam int POS_W     = ADDR_W + 2;
    localparam int IDX_W     = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
    localparam logic [POS_W-1:0] HDR_LEN_P = POS_W'(HDR_MAX_LEN);
    localparam logic [POS_W-1:0] STEP_P    = POS_W'(BYTES_PER_CYCLE);

    cksum_state_e          state_r;
    logic [POS_W-1:0]      pos_r;
    logic [POS_W-1:0]      end_r;
    logic                  mode_r;
    logic                  range_err_r;
    logic [31:0]           acc_r;
    logic [15:0]           cksum_val_r;
    logic                  cksum_ok_r;
    logic                  range_err_out_r;
    logic                  busy_r;
    logic                  ready_r;

    logic [7:0]            hdr_bytes_s  [HDR_MAX_LEN];
    logic [POS_W-1:0]      byte_idx_s   [BYTES_PER_CYCLE];
    logic [7:0]            win_bytes_s  [BYTES_PER_CYCLE];
    logic [16*NUM_WORDS-1:0] words_s;
    logic [19:0]           partial_s;
    logic [POS_W-1:0]      start_sum_s;
    logic                  last_chunk_s;
    logic [16:0]           fold17_s;
    logic [31:0]           seed_s;

`ifdef CKSUM_SEED_EN
    assign seed_s = seed_i;
`else
    assign seed_s = 32'd0;
`endif

    assign start_sum_s  = {2'b00, field_start_i} + {2'b00, field_len_i};
    // Final beat once this beat reaches the window end; a zero-length window still takes one beat.
    assign last_chunk_s = (pos_r + STEP_P) >= end_r;
    assign fold17_s     = fold32to17(acc_r);

    // Split the flat header bus into bytes, index 0 first on the wire.
    always_comb begin
        for (int i = 0; i < HDR_MAX_LEN; i++) begin
            hdr_bytes_s[i] = pkt_hdr_i[8*i +: 8];
        end
    end

    // Fetch this beat's bytes; anything past the window or the header reads as zero.
    always_comb begin
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            byte_idx_s[j] = pos_r + POS_W'(j);
            if ((byte_idx_s[j] < end_r) && (byte_idx_s[j] < HDR_LEN_P)) begin
                win_bytes_s[j] = hdr_bytes_s[byte_idx_s[j][IDX_W-1:0]];
            end else begin
                win_bytes_s[j] = 8'h00;
            end
        end
    end

    // Pair bytes into big-endian words (odd trailing byte gets a zero low byte).
    always_comb begin
        words_s = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            words_s[16*w +: 16] = {win_bytes_s[2*w], win_bytes_s[2*w+1]};
        end
    end

    cksum_word_sum #(
        .NUM_WORDS (NUM_WORDS)
    ) u_word_sum (
        .words   (words_s),
        .partial (partial_s)
    );

    // Control FSM, accumulator and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= FREE;
            pos_r           <= '0;
            end_r           <= '0;
            mode_r          <= 1'b0;
            range_err_r     <= 1'b0;
            acc_r           <= 32'd0;
            cksum_val_r     <= 16'd0;
            cksum_ok_r      <= 1'b0;
            range_err_out_r <= 1'b0;
            busy_r          <= 1'b0;
            ready_r         <= 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    if (start_i) begin
                        pos_r       <= {2'b00, field_start_i};
                        end_r       <= start_sum_s;
                        mode_r      <= mode_i;
                        range_err_r <= (start_sum_s > HDR_LEN_P);
                        acc_r       <= seed_s;
                        busy_r      <= 1'b1;
                        state_r     <= SUM;
                    end
                end
                SUM: begin
                    acc_r <= acc_r + {12'd0, partial_s};
                    pos_r <= pos_r + STEP_P;
                    if (last_chunk_s) begin
                        state_r <= FOLD1;
                    end
                end
                FOLD1: begin
                    acc_r   <= {15'd0, fold17_s};
                    state_r <= FOLD2;
                end
                FOLD2: begin
                    // After the first fold acc fits 17 bits, so this fold fits 16.
                    acc_r           <= {16'd0, fold17_s[15:0]};
                    cksum_val_r     <= ~fold17_s[15:0];
                    cksum_ok_r      <= (mode_r == CKSUM_MODE_VER) &&
                                       (fold17_s[15:0] == CKSUM_ALL_ONES);
                    range_err_out_r <= range_err_r;
                    ready_r         <= 1'b1;
                    busy_r          <= 1'b0;
                    state_r         <= DONE;
                end
                DONE: begin
                    if (!start_i) begin
                        cksum_val_r     <= 16'd0;
                        cksum_ok_r      <= 1'b0;
                        range_err_out_r <= 1'b0;
                        ready_r         <= 1'b0;
                        state_r         <= FREE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    ready_r <= 1'b0;
                    state_r <= FREE;
                end
            endcase
        end
    end

    assign cksum_val_o   = cksum_val_r;
    assign cksum_ok_o    = cksum_ok_r;
    assign range_err_o   = range_err_out_r;
    assign busy_o        = busy_r;
    assign cksum_ready_o = ready_r;

endmodule

// File: tb/tb_cksum_engine.sv
// Directed bench for cksum_engine with hand-computed checksums (default parameters).
// Seed checks are compiled in only when CKSUM_SEED_EN is defined.
module tb_cksum_engine;

    logic         clk;
    logic         rst;
    logic         start;
    logic [511:0] hdr;
    logic [15:0]  fstart;
    logic [15:0]  flen;
    logic         mode;
    logic [31:0]  seed;
    logic [15:0]  val;
    logic         ok;
    logic         err;
    logic         busy;
    logic         ready;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    logic busy_seen;

    cksum_engine dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .pkt_hdr_i     (hdr),
        .field_start_i (fstart),
        .field_len_i   (flen),
        .mode_i        (mode),
`ifdef CKSUM_SEED_EN
        .seed_i        (seed),
`endif
        .cksum_val_o   (val),
        .cksum_ok_o    (ok),
        .range_err_o   (err),
        .busy_o        (busy),
        .cksum_ready_o (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_byte(input int idx, input logic [7:0] v);
        hdr[8*idx +: 8] = v;
    endtask

    task automatic load_ipv4(input logic [7:0] ck_hi, input logic [7:0] ck_lo);
        logic [159:0] ip;
        ip = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;
        for (int i = 0; i < 64; i++) set_byte(i, 8'hEE);
        for (int i = 0; i < 20; i++) set_byte(i, ip[159-8*i -: 8]);
        set_byte(10, ck_hi);
        set_byte(11, ck_lo);
    endtask

    // Issue a request, scramble the fields after latching, wait for ready.
    task automatic run_req(input int s, input int l, input logic m,
                           output int latency, output logic busy_after);
        @(negedge clk);
        fstart = s[15:0];
        flen   = l[15:0];
        mode   = m;
        start  = 1'b1;
        @(posedge clk);
        #1;
        busy_after = busy;
        fstart     = 16'h0005;
        flen       = 16'h0001;
        mode       = ~m;
        latency    = 1;
        do begin
            @(posedge clk);
            #1;
            latency++;
        end while (!ready && latency < 100);
    endtask

    task automatic release_req();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        hdr    = '0;
        fstart = 16'd0;
        flen   = 16'd0;
        mode   = 1'b0;
        seed   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_val",   {16'd0, val},   32'd0);
        check("reset_ok",    {31'd0, ok},    32'd0);
        check("reset_err",   {31'd0, err},   32'd0);
        check("reset_busy",  {31'd0, busy},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // IPv4 generate, bytes past the window are 0xEE and must be masked
        load_ipv4(8'h00, 8'h00);
        run_req(0, 20, 1'b0, lat, busy_seen);
        check("gen_busy_in_sum", {31'd0, busy_seen}, 32'd1);
        check("gen_latency", lat, 32'd8);
        check("gen_val",  {16'd0, val}, 32'h0000_B861);
        check("gen_ok",   {31'd0, ok},  32'd0);
        check("gen_err",  {31'd0, err}, 32'd0);
        check("gen_busy_done", {31'd0, busy}, 32'd0);
        release_req();
        check("release_ready", {31'd0, ready}, 32'd0);
        check("release_val",   {16'd0, val},   32'd0);

        // IPv4 verify with the correct checksum in place
        load_ipv4(8'hB8, 8'h61);
        run_req(0, 20, 1'b1, lat, busy_seen);
        check("ver_latency", lat, 32'd8);
        check("ver_ok",  {31'd0, ok},  32'd1);
        check("ver_val", {16'd0, val}, 32'd0);
        release_req();

        // Odd length: 0102 + 0300, byte 3 outside window
        hdr = '0;
        set_byte(0, 8'h01); set_byte(1, 8'h02); set_byte(2, 8'h03); set_byte(3, 8'hAA);
        run_req(0, 3, 1'b0, lat, busy_seen);
        check("odd_latency", lat, 32'd4);
        check("odd_val", {16'd0, val}, 32'h0000_FBFD);
        release_req();
        run_req(0, 0, 1'b0, lat, busy_seen);
        check("zero_len_latency", lat, 32'd4);
        check("zero_len_val", {16'd0, val}, 32'h0000_FFFF);
        release_req();

        // End-around carry: FFFF + FFFF folds to FFFF
        set_byte(0, 8'hFF); set_byte(1, 8'hFF); set_byte(2, 8'hFF); set_byte(3, 8'hFF);
        run_req(0, 4, 1'b1, lat, busy_seen);
        check("carry_val", {16'd0, val}, 32'd0);
        check("carry_ok",  {31'd0, ok},  32'd1);
        release_req();

        // Window runs past the header end: bytes 64..67 count as zero
        set_byte(60, 8'h12); set_byte(61, 8'h34); set_byte(62, 8'h56); set_byte(63, 8'h78);
        run_req(60, 8, 1'b0, lat, busy_seen);
        check("range_latency", lat, 32'd5);
        check("range_err", {31'd0, err}, 32'd1);
        check("range_val", {16'd0, val}, 32'h0000_9753);
        release_req();
        run_req(60, 4, 1'b0, lat, busy_seen);
        check("edge_err", {31'd0, err}, 32'd0);
        check("edge_val", {16'd0, val}, 32'h0000_9753);
        release_req();

        // start held through DONE: result holds, no rerun
        load_ipv4(8'h00, 8'h00);
        run_req(0, 20, 1'b0, lat, busy_seen);
        repeat (3) @(posedge clk);
        #1;
        check("hold_ready", {31'd0, ready}, 32'd1);
        check("hold_busy",  {31'd0, busy},  32'd0);
        check("hold_val",   {16'd0, val},   32'h0000_B861);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("drop_ready", {31'd0, ready}, 32'd0);
        run_req(0, 20, 1'b0, lat, busy_seen);
        check("rerun_latency", lat, 32'd8);
        check("rerun_val", {16'd0, val}, 32'h0000_B861);
        release_req();

        // Reset during the second SUM cycle
        @(negedge clk);
        fstart = 16'd0;
        flen   = 16'd20;
        mode   = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd0);
        check("midrst_busy",  {31'd0, busy},  32'd0);
        check("midrst_val",   {16'd0, val},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_req(0, 20, 1'b0, lat, busy_seen);
        check("post_rst_latency", lat, 32'd8);
        check("post_rst_val", {16'd0, val}, 32'h0000_B861);
        release_req();

`ifdef CKSUM_SEED_EN
        hdr = '0;
        set_byte(0, 8'h01); set_byte(1, 8'h02); set_byte(2, 8'h03);
        seed = 32'h0000_FFFF;
        run_req(0, 3, 1'b0, lat, busy_seen);
        check("seed_latency", lat, 32'd4);
        check("seed_val", {16'd0, val}, 32'h0000_FBFD);
        release_req();
        seed = 32'h0000_1000;
        run_req(0, 3, 1'b0, lat, busy_seen);
        check("seed2_val", {16'd0, val}, 32'h0000_EBFD);
        release_req();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cksum_engine.md
Name: cksum_engine

Overview:
Parametrised successor to the single-pass header checksum unit. It computes the 16-bit ones'-complement Internet checksum over a byte window of the parsed header, consuming BYTES_PER_CYCLE bytes per clock.
- Modes: generate (checksum value) and verify (pass/fail flag).
- Handles odd lengths and out-of-range windows.
- Sits between the header parser and the deparser/action stage; used for IPv4/UDP/TCP checksum generation and checking.

Parameters:
HDR_MAX_LEN, 64, number of header bytes presented on pkt_hdr_i; must be ≤ 65536.
BYTES_PER_CYCLE, 4, bytes summed per SUM cycle; even, 2..16.
ADDR_W, 16, width of field_start_i and field_len_i.

Ports:
clk  in  1  clock
rst  in  1  reset
start_i  in  1  level request; sampled in FREE
pkt_hdr_i  in  8 x HDR_MAX_LEN  header byte array, index 0 = first byte on wire
field_start_i  in  ADDR_W  first byte of window
field_len_i  in  ADDR_W  window length in bytes; 0 is allowed
mode_i  in  1  0 = generate, 1 = verify
cksum_val_o  out  16  ones'-complement of folded sum
cksum_ok_o  out  1  verify result; folded sum == 16'hFFFF
range_err_o  out  1  window exceeded HDR_MAX_LEN
busy_o  out  1  high in SUM or FOLD
cksum_ready_o  out  1  result valid

Behaviour:
- Reset: rst is synchronous and active-high. It forces state FREE and drives all outputs to 0. The accumulator and latched fields also reset to 0.
- Reset mid-operation aborts the computation. cksum_ready_o is 0 on the cycle after rst is sampled high.
- States and transitions:
  - FREE → SUM when start_i = 1. This latches field_start_i, field_len_i and mode_i, and computes N = max(1, ceil(len/BYTES_PER_CYCLE)).
  - SUM (N cycles): on cycle k, add the big-endian 16-bit words from bytes [start + k·B, start + k·B + B − 1] into a 32-bit accumulator.
  - FOLD1: acc = acc[31:16] + acc[15:0].
  - FOLD2: same fold again; the result fits in 16 bits.
  - DONE: register all outputs and assert cksum_ready_o.
- Latency: if start is sampled at cycle t, cksum_ready_o is high from cycle t+N+3.
- DONE holds while start_i = 1. When start_i = 0 in DONE, go to FREE and clear ready, val, ok and err in the same transition. No new request is accepted until start_i has dropped.
- Window masking: bytes with index ≥ start + len are treated as 0. An odd final byte is therefore padded with a zero low byte.
- Range check: bytes with index ≥ HDR_MAX_LEN read as 0. range_err_o is set if start + len > HDR_MAX_LEN, computed at ADDR_W+1 bits.
- Input stability: pkt_hdr_i must stay stable from the start sample until ready. Changes to field_start_i, field_len_i and mode_i after latching are ignored.
- Results:
  - cksum_val_o = ~fold16 in both modes.
  - cksum_ok_o = (fold16 == 16'hFFFF) in verify mode; 0 in generate mode.
- Accumulator width: 32 bits is sufficient; max is HDR_MAX_LEN/2 · 0xFFFF < 2^31.
- busy_o = (state == SUM || state == FOLD1 || state == FOLD2).

Optional Feature:
CKSUM_SEED_EN
- Defined: adds input seed_i [31:0], latched with the window at start and used as the initial accumulator value. This carries a pre-summed pseudo-header for UDP/TCP.
- Undefined: no seed_i port; the accumulator starts at 0.
- Latency is unchanged in both cases.

Decomposition:
- Package cksum_pkg holds:
  - the state enum cksum_state_e (FREE, SUM, FOLD1, FOLD2, DONE);
  - CKSUM_MODE_GEN = 1'b0 and CKSUM_MODE_VER = 1'b1;
  - the constant CKSUM_ALL_ONES = 16'hFFFF;
  - a function fold32to17.
- Sub-module cksum_word_sum: a combinational adder tree that sums BYTES_PER_CYCLE/2 masked 16-bit words into a 20-bit partial. It is instantiated once, in the SUM datapath.

Test Plan:
1. IPv4 header bytes 45 00 00 73 00 00 40 00 40 11 00 00 c0 a8 00 01 c0 a8 00 c7, start 0, len 20, generate, B=4 → cksum_val_o = 16'hB861; ready exactly 8 cycles after start; ok = 0; err = 0.
2. Same header with bytes 10–11 = b8 61, verify mode → cksum_ok_o = 1, cksum_val_o = 16'h0000.
3. Bytes 01 02 03, len 3 → sum 0x0402, cksum_val_o = 16'hFBFD. Len 0 → 16'hFFFF, ready at t+4.
4. Bytes FF FF FF FF, len 4 → end-around carry gives fold 0xFFFF, cksum_val_o = 16'h0000. Start 60, len 8, HDR_MAX_LEN 64 → range_err_o = 1, bytes 64..67 summed as 0.
5. start_i held high across DONE → no second run and ready stays high. Drop start_i for one cycle and raise it again → second result arrives N+3 cycles later.
6. rst asserted in the 2nd SUM cycle → next cycle all outputs 0, state FREE. A following request produces the correct value. With CKSUM_SEED_EN and seed 0x0000FFFF on case 3 → cksum_val_o = 16'hFBFD.
